// File: rtl/dir_stabilizer.sv
// dir_stabilizer: debounces detector direction codes, commits stable ones and counts committed changes
module dir_stabilizer #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_dir,
    input  logic       i_valid,
    output logic [2:0] o_dir,
    output logic       o_valid,
    output logic       o_change,
    output logic [7:0] o_changes
);
    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

    localparam logic [3:0]  RUN_MAX = 4'(STABLE_CNT);
    localparam logic [15:0] SIL_MAX = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  cand_q, cand_d;
    logic [3:0]  run_q, run_d;
    logic [15:0] sil_q, sil_d;
    logic [2:0]  dir_q, dir_d;
    logic        valid_q, valid_d;
    logic        change_q, change_d;
    logic [7:0]  changes_q, changes_d;
    logic [2:0]  track_cand;
    logic [3:0]  track_run;
    logic        stable, timeout, commit, drop;

    // candidate run tracking and silence counting; gaps without i_valid never break a run
    always_comb begin
        track_cand = cand_q;
        track_run  = run_q;
        if (i_valid) begin
            track_cand = (i_dir == cand_q && run_q != 4'd0) ? cand_q : i_dir;
            track_run  = (i_dir == cand_q && run_q != 4'd0) ? ((run_q == RUN_MAX) ? run_q : run_q + 4'd1) : 4'd1;
        end
        sil_d   = i_valid ? 16'd0 : ((sil_q == SIL_MAX) ? sil_q : sil_q + 16'd1);
        stable  = i_valid && track_run == RUN_MAX;
        timeout = !i_valid && sil_d == SIL_MAX;
    end

    // state decision: commit a stable new code, or drop everything on silence
    always_comb begin
        commit = 1'b0;
        drop   = 1'b0;
        case (state_q)
            S_IDLE: commit = stable;
            S_ACQ: begin
                commit = stable;
                drop   = timeout;
            end
            S_LOCK: begin
                commit = stable && track_cand != dir_q;
                drop   = timeout;
            end
            default: drop = 1'b1;
        endcase
        state_d   = commit ? S_LOCK : drop ? S_IDLE : (state_q == S_IDLE && i_valid) ? S_ACQ : state_q;
        cand_d    = drop ? 3'd0 : track_cand;
        run_d     = drop ? 4'd0 : track_run;
        dir_d     = commit ? track_cand : drop ? 3'd0 : dir_q;
        valid_d   = commit | (~drop & valid_q);
        change_d  = commit;
        changes_d = changes_q + {7'd0, commit};
    end

    // state and output registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            cand_q    <= 3'd0;
            run_q     <= 4'd0;
            sil_q     <= 16'd0;
            dir_q     <= 3'd0;
            valid_q   <= 1'b0;
            change_q  <= 1'b0;
            changes_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            sil_q     <= sil_d;
            dir_q     <= dir_d;
            valid_q   <= valid_d;
            change_q  <= change_d;
            changes_q <= changes_d;
        end
    end

    assign o_dir     = dir_q;
    assign o_valid   = valid_q;
    assign o_change  = change_q;
    assign o_changes = changes_q;
endmodule
